// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding initiator for a word-only data memory.
// Sub-word stores use read-modify-write; misaligned, out-of-range and
// illegal-funct3 requests are answered without touching memory.
module load_store_unit #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [2:0]  reqFunct3,
    input  logic [31:0] reqAdr,
    input  logic [31:0] reqStoreData,
    output logic        rspValid,
    output logic [31:0] rspLoadData,
    output logic        rspMisaligned,
    output logic        rspFault,
    output logic [31:0] dataAdr,
    output logic [31:0] writeData,
    output logic        writeEnable,
    input  logic [31:0] readData
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    // Only the low half of store data is needed after accept; SW bypasses to merged_q.
    logic [15:0] store_lo_q, store_lo_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_mis_q, rsp_mis_d;
    logic        rsp_fault_q, rsp_fault_d;

    logic        accept;
    logic        req_illegal, req_mis, req_fault;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_fmt;
    logic [31:0] merge_word;

    // Request-field error checks, evaluated on the live request in IDLE.
    always_comb begin
        accept      = reqValid && (state_q == StIdle) && !reset;
        req_illegal = (reqFunct3 == 3'b011) || (reqFunct3 == 3'b110) ||
                      (reqFunct3 == 3'b111) || (reqWrite && reqFunct3[2]);
        req_mis     = ((reqFunct3[1:0] == 2'b01) && reqAdr[0]) ||
                      ((reqFunct3[1:0] == 2'b10) && (reqAdr[1:0] != 2'b00));
        req_fault   = ({2'b00, reqAdr[31:2]} >= MEM_SIZE) || req_illegal;
    end

    // Load formatting and sub-word merge from the word read in READ.
    always_comb begin
        lane_byte = 8'h00;
        unique case (adr_q[1:0])
            2'd0: lane_byte = readData[7:0];
            2'd1: lane_byte = readData[15:8];
            2'd2: lane_byte = readData[23:16];
            2'd3: lane_byte = readData[31:24];
        endcase
        lane_half = adr_q[1] ? readData[31:16] : readData[15:0];

        case (funct3_q[1:0])
            2'b00:   load_fmt = funct3_q[2] ? {24'h0, lane_byte}
                                            : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_fmt = funct3_q[2] ? {16'h0, lane_half}
                                            : {{16{lane_half[15]}}, lane_half};
            default: load_fmt = readData;
        endcase

        merge_word = readData;
        if (funct3_q[1:0] == 2'b00) begin
            unique case (adr_q[1:0])
                2'd0: merge_word[7:0]   = store_lo_q[7:0];
                2'd1: merge_word[15:8]  = store_lo_q[7:0];
                2'd2: merge_word[23:16] = store_lo_q[7:0];
                2'd3: merge_word[31:24] = store_lo_q[7:0];
            endcase
        end else if (adr_q[1]) begin
            merge_word[31:16] = store_lo_q;
        end else begin
            merge_word[15:0] = store_lo_q;
        end
    end

    // Next-state and capture logic.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        funct3_d    = funct3_q;
        write_d     = write_q;
        store_lo_d  = store_lo_q;
        merged_d    = merged_q;
        rsp_data_d  = rsp_data_q;
        rsp_mis_d   = rsp_mis_q;
        rsp_fault_d = rsp_fault_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    adr_d      = reqAdr;
                    funct3_d   = reqFunct3;
                    write_d    = reqWrite;
                    store_lo_d = reqStoreData[15:0];
                    if (req_mis || req_fault) begin
                        rsp_data_d  = 32'h0;
                        rsp_mis_d   = req_mis;
                        rsp_fault_d = req_fault;
                        state_d     = StResp;
                    end else if (reqWrite && (reqFunct3 == 3'b010)) begin
                        merged_d = reqStoreData;
                        state_d  = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (write_q) begin
                    merged_d = merge_word;
                    state_d  = StWrite;
                end else begin
                    rsp_data_d  = load_fmt;
                    rsp_mis_d   = 1'b0;
                    rsp_fault_d = 1'b0;
                    state_d     = StResp;
                end
            end
            StWrite: begin
                rsp_data_d  = 32'h0;
                rsp_mis_d   = 1'b0;
                rsp_fault_d = 1'b0;
                state_d     = StResp;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            adr_q       <= 32'h0;
            funct3_q    <= 3'h0;
            write_q     <= 1'b0;
            store_lo_q  <= 16'h0;
            merged_q    <= 32'h0;
            rsp_data_q  <= 32'h0;
            rsp_mis_q   <= 1'b0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            funct3_q    <= funct3_d;
            write_q     <= write_d;
            store_lo_q  <= store_lo_d;
            merged_q    <= merged_d;
            rsp_data_q  <= rsp_data_d;
            rsp_mis_q   <= rsp_mis_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Memory port and response outputs.
    always_comb begin
        reqReady      = (state_q == StIdle);
        rspValid      = (state_q == StResp);
        rspLoadData   = rsp_data_q;
        rspMisaligned = rsp_mis_q;
        rspFault      = rsp_fault_q;
        dataAdr       = ((state_q == StRead) || (state_q == StWrite)) ?
                        {adr_q[31:2], 2'b00} : 32'h0;
        writeData     = (state_q == StWrite) ? merged_q : 32'h0;
        writeEnable   = (state_q == StWrite) && !reset;
    end

endmodule
